// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between instruction fetch and the
// load/store path; load/store has priority, bounded by a fetch starvation counter.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam int unsigned     CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_e;

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               ls_win;

    assign ls_win = ls_req && (!if_req || (starve_cnt_q < CNT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;

        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        ls_gnt    = 1'b0;
        ls_rvalid = 1'b0;
        ls_rdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (ls_win) begin
                    ls_gnt  = 1'b1;
                    owner_d = OWN_LS;
                    addr_d  = ls_addr;
                    wdata_d = ls_wdata;
                    we_d    = ls_we;
                    state_d = ST_ISSUE;
                    // LS can only beat a pending fetch while below CNT_MAX, so
                    // the increment never overflows the saturation point.
                    starve_cnt_d = if_req ? starve_cnt_q + 1'b1 : '0;
                end else if (if_req) begin
                    if_gnt       = 1'b1;
                    owner_d      = OWN_IF;
                    addr_d       = if_addr;
                    wdata_d      = '0;
                    we_d         = 1'b0;
                    starve_cnt_d = '0;
                    state_d      = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ready) begin
                    if (we_q) begin
                        ls_rvalid = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (mem_rvalid) begin
                    if (owner_q == OWN_LS) begin
                        ls_rvalid = 1'b1;
                        ls_rdata  = mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters, MAX_WAIT = 4).
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "time limit expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    logic exp_if_seq [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic got_if_seq [10];
    int unsigned n_gnt;

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset state
        next_cycle(); next_cycle(); settle();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_outs", {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_we}, 0);
        check_eq("rst_data", {mem_addr, mem_wdata | if_rdata | ls_rdata}, 0);
        next_cycle(); rst_n = 1'b1;

        // Single fetch
        next_cycle(); if_req = 1'b1; if_addr = 32'h100; settle();
        check_eq("f_if_gnt", if_gnt, 1);
        check_eq("f_ls_gnt", ls_gnt, 0);
        next_cycle(); if_req = 1'b0; mem_ready = 1'b1; settle();
        check_eq("f_mem_req", mem_req, 1);
        check_eq("f_mem_addr", mem_addr, 32'h100);
        check_eq("f_mem_we", mem_we, 0);
        check_eq("f_busy", busy, 1);
        next_cycle(); mem_ready = 1'b0; settle();
        check_eq("f_wait_req", mem_req, 0);
        check_eq("f_wait_rv", {if_rvalid, ls_rvalid}, 0);
        next_cycle(); mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; settle();
        check_eq("f_if_rvalid", if_rvalid, 1);
        check_eq("f_if_rdata", if_rdata, 32'hDEADBEEF);
        check_eq("f_ls_rvalid", ls_rvalid, 0);
        next_cycle(); mem_rvalid = 1'b0; settle();
        check_eq("f_idle_busy", busy, 0);
        check_eq("f_idle_rv", if_rvalid, 0);

        // Store with a two-cycle mem_ready stall; stray mem_rvalid in ISSUE ignored
        next_cycle(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2000; ls_wdata = 32'h55; settle();
        check_eq("s_ls_gnt", ls_gnt, 1);
        next_cycle(); ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; mem_rvalid = 1'b1; settle();
        check_eq("s_stall1", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h2000, 32'h55});
        check_eq("s_stall1_rv", ls_rvalid, 0);
        next_cycle(); mem_rvalid = 1'b0; settle();
        check_eq("s_stall2", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h2000, 32'h55});
        check_eq("s_stall2_rv", ls_rvalid, 0);
        next_cycle(); mem_ready = 1'b1; settle();
        check_eq("s_ack", {ls_rvalid, ls_rdata, if_rvalid}, {1'b1, 32'h0, 1'b0});
        next_cycle(); mem_ready = 1'b0; settle();
        check_eq("s_busy_drop", busy, 0);
        check_eq("s_ack_gone", ls_rvalid, 0);

        // Load beats a pending fetch; data routed to LS only
        next_cycle(); if_req = 1'b1; if_addr = 32'h300; ls_req = 1'b1; ls_addr = 32'h40; settle();
        check_eq("l_ls_gnt", ls_gnt, 1);
        check_eq("l_if_gnt", if_gnt, 0);
        next_cycle(); ls_req = 1'b0; mem_ready = 1'b1; settle();
        check_eq("l_mem_addr", mem_addr, 32'h40);
        check_eq("l_no_gnt_issue", {if_gnt, ls_gnt}, 0);
        next_cycle(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234; settle();
        check_eq("l_ls_rv", {ls_rvalid, ls_rdata}, {1'b1, 32'h1234});
        check_eq("l_if_rv", {if_rvalid, if_rdata}, 0);
        // Second load while fetch still waits (starve counter becomes 2)
        next_cycle(); mem_rvalid = 1'b0; ls_req = 1'b1; ls_addr = 32'h44; settle();
        check_eq("l2_ls_gnt", {ls_gnt, if_gnt}, 2'b10);
        next_cycle(); ls_req = 1'b0; if_req = 1'b0; mem_ready = 1'b1; settle();
        check_eq("l2_mem_addr", mem_addr, 32'h44);
        next_cycle(); mem_ready = 1'b0; settle();
        check_eq("l2_wait_busy", busy, 1);

        // Reset mid-WAIT, then a stale mem_rvalid
        next_cycle(); rst_n = 1'b0; settle();
        check_eq("r_busy", busy, 0);
        check_eq("r_outs", {mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid}, 0);
        next_cycle(); rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555; settle();
        check_eq("r_stale_rv", {if_rvalid, ls_rvalid}, 0);
        check_eq("r_stale_data", {if_rdata, ls_rdata}, 0);
        check_eq("r_stale_busy", busy, 0);

        // Contention with zero-latency memory; reset must have cleared the counter
        next_cycle(); mem_rvalid = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0;
        if_req = 1'b1; if_addr = 32'h500; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h600;
        n_gnt = 0;
        for (int unsigned c = 0; c < 60 && n_gnt < 10; c++) begin
            if (c != 0) next_cycle();
            settle();
            if (if_gnt && ls_gnt) check_eq("c_dual_gnt", {if_gnt, ls_gnt}, 2'b01);
            if (if_gnt || ls_gnt) begin
                got_if_seq[n_gnt] = if_gnt;
                n_gnt++;
            end
        end
        check_eq("c_grant_count", n_gnt, 10);
        for (int unsigned i = 0; i < 10; i++)
            if (i < n_gnt) check_eq($sformatf("c_gnt%0d_is_if", i), got_if_seq[i], exp_if_seq[i]);
        next_cycle(); if_req = 1'b0; ls_req = 1'b0;
        next_cycle(); next_cycle(); mem_ready = 1'b0; mem_rvalid = 1'b0;
        next_cycle(); settle();
        check_eq("c_drain_busy", busy, 0);

        // Back-to-back loads: second request held through the first
        next_cycle(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80; settle();
        check_eq("b_gnt1", ls_gnt, 1);
        next_cycle(); ls_addr = 32'h84; settle();
        check_eq("b_no_gnt_issue", ls_gnt, 0);
        next_cycle(); mem_ready = 1'b1; settle();
        check_eq("b_addr1", {ls_gnt, mem_addr}, {1'b0, 32'h80});
        next_cycle(); mem_ready = 1'b0; settle();
        check_eq("b_no_gnt_wait", ls_gnt, 0);
        next_cycle(); mem_rvalid = 1'b1; mem_rdata = 32'h77; settle();
        check_eq("b_rv1", {ls_gnt, ls_rvalid, ls_rdata}, {2'b01, 32'h77});
        next_cycle(); mem_rvalid = 1'b0; settle();
        check_eq("b_gnt2", {ls_gnt, ls_rvalid}, 2'b10);
        next_cycle(); ls_req = 1'b0; mem_ready = 1'b1; settle();
        check_eq("b_addr2", mem_addr, 32'h84);
        next_cycle(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99; settle();
        check_eq("b_rv2", {ls_rvalid, ls_rdata}, {1'b1, 32'h99});
        next_cycle(); mem_rvalid = 1'b0; settle();
        check_eq("b_end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
